// File: rtl/cnn_pkg.sv
// Shared types and tap-index helpers for the 3x3 convolution stage.
package cnn_pkg;

  localparam int PIX_W = 8;
  localparam int WGT_W = 8;
  localparam int ACC_W = 21;

  typedef enum logic [2:0] {IDLE, LOAD_W, FETCH, EMIT, FIN} state_t;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [WGT_W-1:0] wgt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Window row/column of tap k (k = ky*3 + kx); values past 8 are don't-care.
  function automatic logic [1:0] tap_row(input logic [3:0] k);
    if (k < 4'd3)      return 2'd0;
    else if (k < 4'd6) return 2'd1;
    else               return 2'd2;
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cnn_mac.sv
// Signed weight x unsigned pixel accumulator with ReLU, arithmetic shift and
// saturation of the running sum to an 8-bit feature value.
module cnn_mac
  import cnn_pkg::*;
#(
  parameter int SHIFT = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  wgt_t wgt,
  input  pix_t pix,
  output pix_t feat
);

  logic signed [16:0] wgt_ext;
  logic signed [16:0] pix_ext;
  logic signed [16:0] prod;
  acc_t               acc_reg;
  acc_t               shifted;

  assign wgt_ext = {{(17-WGT_W){wgt[WGT_W-1]}}, wgt};
  assign pix_ext = {{(17-PIX_W){1'b0}}, pix};
  assign prod    = wgt_ext * pix_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_W'(prod);
    end
  end

  assign shifted = acc_reg >>> SHIFT;

  // A non-negative sum with any bit set above the feature width saturates.
  always_comb begin
    feat = '0;
    if (acc_reg[ACC_W-1])
      feat = '0;
    else if (|shifted[ACC_W-1:PIX_W])
      feat = '1;
    else
      feat = shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/cnn_conv3x3.sv
// Valid 3x3 convolution over an image held in a one-cycle-latency memory;
// loads nine weights, then streams one feature per output pixel.
module cnn_conv3x3
  import cnn_pkg::*;
#(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int AW       = 9,
  parameter int W_BASE   = 0,
  parameter int IMG_BASE = 16,
  parameter int SHIFT    = 4
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [3:0] TAPS = 4'd9;

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [3:0]    rd_idx_reg;
  logic          rd_valid_reg;
  logic [XW-1:0] ox_reg;
  logic [YW-1:0] oy_reg;
  wgt_t          wgt_arr [0:8];
  logic [31:0]   pix_off;
  logic          last_pix;
  logic          mac_clr;
  logic          mac_en;
  pix_t          feat;

  assign last_pix = (ox_reg == XW'(IMG_W-3)) && (oy_reg == YW'(IMG_H-3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ox_reg    <= '0;
      oy_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD_W;
            cnt_reg   <= '0;
          end
        end
        LOAD_W: begin
          if (cnt_reg == TAPS) begin
            state_reg <= FETCH;
            cnt_reg   <= '0;
            ox_reg    <= '0;
            oy_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        // cnt 0..8 issue reads; cnt 9 is the drain cycle for the last datum
        FETCH: begin
          if (cnt_reg == TAPS)
            state_reg <= EMIT;
          else
            cnt_reg <= cnt_reg + 4'd1;
        end
        EMIT: begin
          if (out_ready) begin
            if (last_pix) begin
              state_reg <= FIN;
            end else begin
              state_reg <= FETCH;
              cnt_reg   <= '0;
              if (ox_reg == XW'(IMG_W-3)) begin
                ox_reg <= '0;
                oy_reg <= oy_reg + YW'(1);
              end else begin
                ox_reg <= ox_reg + XW'(1);
              end
            end
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag each read so the returning datum knows which tap it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
      rd_idx_reg   <= '0;
    end else begin
      rd_valid_reg <= mem_rd;
      rd_idx_reg   <= cnt_reg;
    end
  end

  genvar gi;
  for (gi = 0; gi < 9; gi++) begin : g_wgt
    wgt_t w_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        w_reg <= '0;
      else if (state_reg == LOAD_W && rd_valid_reg && rd_idx_reg == 4'(gi))
        w_reg <= wgt_t'(mem_rdata);
    end
    assign wgt_arr[gi] = w_reg;
  end

  assign pix_off = (32'(oy_reg) + 32'(tap_row(cnt_reg))) * 32'(IMG_W)
                 + 32'(ox_reg) + 32'(tap_col(cnt_reg));

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (state_reg == LOAD_W && cnt_reg < TAPS) begin
      mem_rd   = 1'b1;
      mem_addr = AW'(W_BASE) + AW'(cnt_reg);
    end else if (state_reg == FETCH && cnt_reg < TAPS) begin
      mem_rd   = 1'b1;
      mem_addr = AW'(IMG_BASE) + pix_off[AW-1:0];
    end
  end

  assign mac_clr = (state_reg == FETCH) && (cnt_reg == 4'd0);
  assign mac_en  = (state_reg == FETCH) && rd_valid_reg;

  cnn_mac #(
    .SHIFT (SHIFT)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .wgt   (wgt_arr[rd_idx_reg]),
    .pix   (mem_rdata),
    .feat  (feat)
  );

  assign busy      = (state_reg == LOAD_W) || (state_reg == FETCH) || (state_reg == EMIT);
  assign done      = (state_reg == FIN);
  assign out_valid = (state_reg == EMIT);
  assign out_last  = (state_reg == EMIT) && last_pix;
  assign out_data  = (state_reg == EMIT) ? feat : 8'd0;

endmodule

// File: tb/tb_cnn_conv3x3.sv
// Directed bench: two instances (SHIFT=4 and SHIFT=0) share one image memory
// and run in lockstep; each frame's outputs are checked against hand values.
module tb_cnn_conv3x3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;

  logic       busy4, done4, rd4, valid4, last4;
  logic [8:0] addr4;
  logic [7:0] rdata4, data4;
  logic       busy0, done0, rd0, valid0, last0;
  logic [8:0] addr0;
  logic [7:0] rdata0, data0;

  logic [7:0] mem [0:511];
  int         exp4 [0:195];
  int         exp0 [0:195];
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  cnn_conv3x3 #(.SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .busy(busy4), .done(done4),
    .mem_addr(addr4), .mem_rd(rd4), .mem_rdata(rdata4),
    .out_valid(valid4), .out_ready(out_ready), .out_data(data4), .out_last(last4)
  );

  cnn_conv3x3 #(.SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .mem_addr(addr0), .mem_rd(rd0), .mem_rdata(rdata0),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .out_last(last0)
  );

  // Junk on non-read cycles makes sure stale data is never consumed.
  always @(posedge clk) begin
    rdata4 <= rd4 ? mem[addr4] : 8'($urandom);
    rdata0 <= rd0 ? mem[addr0] : 8'($urandom);
  end

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  task automatic set_uniform(input int e4, input int e0);
    for (int n = 0; n < 196; n++) begin
      exp4[n] = e4;
      exp0[n] = e0;
    end
  endtask

  task automatic load_weights(input logic [7:0] w0, input logic [7:0] wrest);
    for (int k = 0; k < 9; k++) mem[k] = (k == 0) ? w0 : wrest;
  endtask

  task automatic run_frame(input string name, input bit stall, input bit restart, input int abort_at);
    int cyc, nout, first_v, last_hs;
    logic [7:0] held_d;
    logic held_l;
    bit fin;
    cyc = 0; nout = 0; first_v = -1; last_hs = -1; fin = 0;
    held_d = '0; held_l = 1'b0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    check("busy_idle", busy4, 0);
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (restart && cyc == 100) start = 1'b1;
      if (restart && cyc == 101) start = 1'b0;
      out_ready = !(stall && cyc >= 21 && cyc <= 25);
      if (cyc == 1) check("busy_after_start", busy4, 1);
      if (cyc == abort_at) begin
        check("rd_before_abort", rd4, 1);
        reset = 1'b0;
        #1;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_rd", rd4, 0);
        check("rst_addr", addr4, 0);
        check("rst_valid", valid4, 0);
        check("rst_data", data4, 0);
        check("rst_last", last4, 0);
        check("rst_busy0", busy0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("frame %s aborted by reset at cycle %0d after %0d outputs", name, cyc, nout);
        return;
      end
      if (valid4 && first_v < 0) begin
        first_v = cyc;
        held_d = data4;
        held_l = last4;
      end
      if (stall && cyc >= 21 && cyc <= 26) begin
        check("stall_valid", valid4, 1);
        check("stall_data", data4, held_d);
        check("stall_last", last4, held_l);
        check("stall_rd", rd4, 0);
      end
      if (stall && cyc == 27) begin
        check("refetch_rd", rd4, 1);
        check("refetch_addr", addr4, 17);
      end
      if (valid4 && out_ready) begin
        if (nout < 196) begin
          check("data_s4", data4, exp4[nout]);
          check("data_s0", data0, exp0[nout]);
        end else begin
          check("extra_output", nout, 195);
        end
        check("out_last", last4, (nout == 195) ? 1 : 0);
        nout++;
        last_hs = cyc;
      end
      if (done4) begin
        check("done_timing", cyc, last_hs + 1);
        check("busy_at_done", busy4, 0);
        fin = 1;
      end
    end
    if (!fin) check("timeout", 0, 1);
    check("out_count", nout, 196);
    check("first_valid", first_v, 21);
    if (!stall) check("last_handshake", last_hs, 2166);
    @(negedge clk);
    check("done_pulse", done4, 0);
    check("busy_after", busy4, 0);
    $display("frame %s outputs=%0d first_valid=%0d last_handshake=%0d", name, nout, first_v, last_hs);
  endtask

  initial begin
    int v;
    for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);
    repeat (2) @(negedge clk);
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_rd", rd4, 0);
    check("reset_addr", addr4, 0);
    check("reset_valid", valid4, 0);
    check("reset_data", data4, 0);
    check("reset_last", last4, 0);
    reset = 1'b1;

    load_weights(8'h00, 8'h00);
    set_uniform(0, 0);
    run_frame("zero_weights", 0, 0, 0);

    load_weights(8'h00, 8'h00);
    mem[4] = 8'h01;
    for (int i = 0; i < 256; i++) mem[16+i] = 8'(i);
    for (int n = 0; n < 196; n++) begin
      v = ((n % 14) + 1 + 16 * ((n / 14) + 1)) & 255;
      exp0[n] = v;
      exp4[n] = v >> 4;
    end
    run_frame("identity", 0, 0, 0);
    run_frame("identity_stall", 1, 0, 0);

    load_weights(8'h01, 8'h01);
    for (int i = 0; i < 256; i++) mem[16+i] = 8'd255;
    set_uniform(143, 255);
    run_frame("ones_restart", 0, 1, 0);

    load_weights(8'hFF, 8'hFF);
    for (int i = 0; i < 256; i++) mem[16+i] = 8'd200;
    set_uniform(0, 0);
    run_frame("relu", 0, 0, 0);

    load_weights(8'h80, 8'h7F);
    for (int i = 0; i < 256; i++) mem[16+i] = 8'd1;
    set_uniform(55, 255);
    run_frame("mixed_abort", 0, 0, 15);
    run_frame("mixed_after_reset", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_conv3x3.md
Name: cnn_conv3x3

Overview:
- Compute stage directly downstream of the CNN parameter/image memory.
- After a start pulse, reads nine signed 8-bit weights and an 8-bit grayscale card image from that memory through a read port with one-cycle latency.
- Performs a valid (no-padding) 3x3 convolution with ReLU, shift and saturation.
- Streams one 8-bit feature value per output pixel to the next layer over a valid/ready interface.

Parameters:
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
AW, 9, memory address width
W_BASE, 0, address of weight 0 (weights row-major at W_BASE..W_BASE+8)
IMG_BASE, 16, address of pixel (0,0); pixel (x,y) at IMG_BASE+y*IMG_W+x
SHIFT, 4, right-shift applied after ReLU

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle start request
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final output handshake
mem_addr  out  AW  read address
mem_rd  out  1  read strobe
mem_rdata  in  8  read data, valid the cycle after mem_rd
out_valid  out  1  output data valid
out_ready  in  1  consumer ready
out_data  out  8  unsigned feature value
out_last  out  1  high with the final output of the frame

Behaviour:
- Reset (reset low, any time, including mid-frame):
  - Return to IDLE.
  - busy, done, mem_rd, out_valid and out_last go to 0; mem_addr and out_data go to 0.
  - Accumulator, counters and weight registers clear.
  - No output is produced for a partially fetched pixel.
- States: IDLE, LOAD_W, FETCH, EMIT, FIN.
- IDLE:
  - start=1 -> LOAD_W; busy=1 from the next cycle.
  - start while not in IDLE is ignored.
- LOAD_W:
  - mem_rd=1 on 9 consecutive cycles, addresses W_BASE+0..8.
  - Each mem_rdata is captured as signed weight k one cycle after its read.
  - After the 9th datum is captured -> FETCH with ox=oy=0.
- FETCH:
  - For window k=0..8 (ky=k/3, kx=k%3), issue mem_rd at IMG_BASE+(oy+ky)*IMG_W+(ox+kx) on 9 consecutive cycles.
  - Accumulate acc += w[k]*pixel as data returns.
  - Pixel is zero-extended unsigned; the product is 17-bit signed; acc is 21-bit signed and cleared at the start of each window.
  - Overflow is impossible: max |acc| = 293760.
  - Cycle after the last datum -> EMIT.
- EMIT:
  - out_data = 0 if acc<0, else min(acc>>>SHIFT, 255).
  - out_valid=1, held with out_data and out_last stable until out_ready=1.
  - No mem_rd while in EMIT.
  - On handshake: if this was the last output -> FIN; else advance ox (wrap to 0 at IMG_W-3, then increment oy) -> FETCH.
- out_last: 1 only during EMIT of (ox,oy)=(IMG_W-3,IMG_H-3).
- Output count per frame: (IMG_W-2)*(IMG_H-2), i.e. 196 at defaults.
- FIN: done=1 for one cycle, busy=0 -> IDLE. A new start is accepted the cycle after FIN.
- Latency:
  - Weight load is 10 cycles.
  - Each output takes 11 cycles with out_ready tied high: 9 reads, 1 drain, 1 emit.
  - First out_valid appears 21 cycles after the start cycle.
- out_ready is ignored when out_valid=0.
- mem_rdata is ignored on cycles not following a mem_rd.

Decomposition:
- Package cnn_pkg holds:
  - constants PIX_W=8, WGT_W=8, ACC_W=21;
  - typedef state_t enum {IDLE, LOAD_W, FETCH, EMIT, FIN};
  - typedefs pix_t (logic [7:0]), wgt_t (logic signed [7:0]), acc_t (logic signed [20:0]).
- One sub-module, cnn_mac:
  - performs the clear/accumulate of acc_t;
  - performs the combinational ReLU-shift-saturate to pix_t.
- The FSM, address generation and stream handshake stay in cnn_conv3x3.

Test Plan:
- All weights 0, arbitrary image, out_ready=1 -> 196 outputs all 0; out_last only on the 196th; done pulse one cycle after it; busy low afterwards.
- Weight 4 = 1, others 0, SHIFT=0, pixel(x,y)=(x+16*y)&0xFF -> output n equals pixel (ox+1, oy+1), e.g. first output 17, last output 238.
- All weights 1, all pixels 255: SHIFT=4 -> every output 143 (2295>>4); SHIFT=0 -> every output 255 (saturated).
- All weights -1, pixels 200 -> every output 0 (ReLU); weight 0 = -128 with others 127 and pixels 1 -> acc=888 -> 55 at SHIFT=4.
- out_ready low for 5 cycles during the first EMIT -> out_valid, out_data and out_last stable; mem_rd stays 0; the next FETCH starts the cycle after the handshake.
- Second start pulse mid-frame is ignored (output count still 196).
- Reset asserted mid-FETCH -> all outputs 0 immediately; a fresh start yields a correct full frame.
